// File: rtl/gpr_wb_sched.sv
`default_nettype none
// gpr_wb_sched: round-robin writeback arbiter (ALU vs memory) feeding the GPR
// write port, plus a busy scoreboard for issue-stage hazard and WAW checks.
module gpr_wb_sched #(
  parameter int DW   = 16,
  parameter int AW   = 3,
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic [AW-1:0]   chk_rs1,
  input  logic [AW-1:0]   chk_rs2,
  output logic            hz1,
  output logic            hz2,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_rd,
  input  logic [DW-1:0]   a_data,
  output logic            a_ready,
  input  logic            m_valid,
  input  logic [AW-1:0]   m_rd,
  input  logic [DW-1:0]   m_data,
  output logic            m_ready,
  output logic            gpr_we,
  output logic [AW-1:0]   gpr_ws,
  output logic [DW-1:0]   gpr_wd,
  output logic [NREG-1:0] busy
);

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_M = 1'b1
  } grant_e;

  grant_e          r_last;
  grant_e          w_last_nxt;
  logic            w_grant_a;
  logic            w_grant_m;
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic            r_we;
  logic [AW-1:0]   r_ws;
  logic [DW-1:0]   r_wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last <= GRANT_M;
    else        r_last <= w_last_nxt;
  end

  // Grants look only at the valids and the last winner, never at rd/data.
  always_comb begin
    w_grant_a  = 1'b0;
    w_grant_m  = 1'b0;
    w_last_nxt = r_last;
    if (a_valid && m_valid) begin
      if (r_last == GRANT_M) w_grant_a = 1'b1;
      else                   w_grant_m = 1'b1;
    end else begin
      w_grant_a = a_valid;
      w_grant_m = m_valid;
    end
    if (w_grant_a)      w_last_nxt = GRANT_A;
    else if (w_grant_m) w_last_nxt = GRANT_M;
  end

  assign a_ready   = w_grant_a;
  assign m_ready   = w_grant_m;
  assign iss_ready = ~r_busy[iss_rd];
  assign hz1       = r_busy[chk_rs1];
  assign hz2       = r_busy[chk_rs2];

  assign w_set = (iss_valid && iss_ready) ? (NREG'(1) << iss_rd) : {NREG{1'b0}};
  assign w_clr = r_we ? (NREG'(1) << r_ws) : {NREG{1'b0}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= {NREG{1'b0}};
    else        r_busy <= (r_busy & ~w_clr) | w_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we <= 1'b0;
      r_ws <= {AW{1'b0}};
      r_wd <= {DW{1'b0}};
    end else begin
      r_we <= w_grant_a | w_grant_m;
      if (w_grant_a) begin
        r_ws <= a_rd;
        r_wd <= a_data;
      end else if (w_grant_m) begin
        r_ws <= m_rd;
        r_wd <= m_data;
      end
    end
  end

  assign gpr_we = r_we;
  assign gpr_ws = r_ws;
  assign gpr_wd = r_wd;
  assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_sched.sv
`default_nettype none
// Bench for gpr_wb_sched: cycle model of scoreboard/arbiter with a queue of
// expected register-file writes, plus directed checks from the test plan.
module tb_gpr_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [2:0]  iss_rd;
  logic        iss_ready;
  logic [2:0]  chk_rs1, chk_rs2;
  logic        hz1, hz2;
  logic        a_valid;
  logic [2:0]  a_rd;
  logic [15:0] a_data;
  logic        a_ready;
  logic        m_valid;
  logic [2:0]  m_rd;
  logic [15:0] m_data;
  logic        m_ready;
  logic        gpr_we;
  logic [2:0]  gpr_ws;
  logic [15:0] gpr_wd;
  logic [7:0]  busy;

  gpr_wb_sched #(.DW(16), .AW(3), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hz1(hz1), .hz2(hz2),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
    .gpr_we(gpr_we), .gpr_ws(gpr_ws), .gpr_wd(gpr_wd), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] data;
  } wb_t;

  wb_t        exp_q[$];
  logic [7:0] mdl_busy;
  logic       mdl_last_m;
  logic       mdl_we;
  logic [2:0] mdl_ws;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    m_valid = 1'b0; m_rd = '0; m_data = '0;
  endtask

  task automatic model_reset();
    mdl_busy   = '0;
    mdl_last_m = 1'b1;
    mdl_we     = 1'b0;
    mdl_ws     = '0;
    exp_q.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance it.
  task automatic cycle();
    logic       ga, gm;
    logic [7:0] nb;
    wb_t        e;
    @(negedge clk);
    if (a_valid && m_valid) begin
      ga = mdl_last_m;
      gm = !mdl_last_m;
    end else begin
      ga = a_valid;
      gm = m_valid;
    end
    check("a_ready", a_ready, ga);
    check("m_ready", m_ready, gm);
    check("iss_ready", iss_ready, !mdl_busy[iss_rd]);
    check("hz1", hz1, mdl_busy[chk_rs1]);
    check("hz2", hz2, mdl_busy[chk_rs2]);
    check("busy", busy, mdl_busy);
    check("gpr_we", gpr_we, mdl_we);
    if (gpr_we) begin
      check("wb_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gpr_ws", gpr_ws, e.rd);
        check("gpr_wd", gpr_wd, e.data);
      end
    end
    nb = mdl_busy;
    if (mdl_we) nb[mdl_ws] = 1'b0;
    if (iss_valid && !mdl_busy[iss_rd]) nb[iss_rd] = 1'b1;
    @(posedge clk);
    mdl_busy = nb;
    mdl_we   = ga | gm;
    if (ga) begin
      exp_q.push_back('{rd: a_rd, data: a_data});
      mdl_ws = a_rd;
      mdl_last_m = 1'b0;
    end else if (gm) begin
      exp_q.push_back('{rd: m_rd, data: m_data});
      mdl_ws = m_rd;
      mdl_last_m = 1'b1;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();

    // Reset then idle
    check("rst_busy", busy, 8'h00);
    check("rst_we", gpr_we, 1'b0);
    for (int r = 0; r < 8; r++) begin
      chk_rs1 = 3'(r);
      chk_rs2 = 3'(7 - r);
      iss_rd  = 3'(r);
      #1;
      check("rst_hz1", hz1, 1'b0);
      check("rst_hz2", hz2, 1'b0);
      check("rst_iss_ready", iss_ready, 1'b1);
    end
    idle_inputs();
    cycle();

    // Claim r3, WAW stall, hazard
    iss_valid = 1'b1; iss_rd = 3'd3;
    cycle();
    iss_valid = 1'b0;
    check("claim_busy", busy, 8'h08);
    iss_valid = 1'b1; #1;
    check("waw_stall", iss_ready, 1'b0);
    cycle();
    iss_valid = 1'b0;
    chk_rs1 = 3'd3; #1;
    check("hz1_r3", hz1, 1'b1);

    // ALU writeback of r3
    a_valid = 1'b1; a_rd = 3'd3; a_data = 16'hBEEF; #1;
    check("alu_ready", a_ready, 1'b1);
    cycle();
    a_valid = 1'b0; #1;
    check("wb_we", gpr_we, 1'b1);
    check("wb_ws", gpr_ws, 3'd3);
    check("wb_wd", gpr_wd, 16'hBEEF);
    cycle();
    check("retire_busy3", busy[3], 1'b0);
    check("retire_hz1", hz1, 1'b0);
    cycle();

    // Dual contention after reset: A,M,A,M
    apply_reset();
    a_valid = 1'b1; a_rd = 3'd1; a_data = 16'hA001;
    m_valid = 1'b1; m_rd = 3'd6; m_data = 16'hB001;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("arb_seq_a", a_ready, (i % 2) == 0);
      check("arb_one_hot", a_ready & m_ready, 1'b0);
      cycle();
      if (i % 2 == 0) begin
        a_rd = a_rd + 3'd1; a_data = a_data + 16'h0111;
      end else begin
        m_rd = m_rd - 3'd1; m_data = m_data + 16'h0222;
      end
    end
    a_valid = 1'b0; m_valid = 1'b0;
    cycle();
    cycle();

    // Claim r5 in the cycle r2 retires
    iss_valid = 1'b1; iss_rd = 3'd2;
    cycle();
    iss_valid = 1'b0;
    a_valid = 1'b1; a_rd = 3'd2; a_data = 16'h1234;
    cycle();
    a_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 3'd5; #1;
    check("r2_retiring", gpr_ws, 3'd2);
    cycle();
    iss_valid = 1'b0;
    check("claim_r5", busy[5], 1'b1);
    check("retire_r2", busy[2], 1'b0);

    // Reset mid-operation with busy=8'h24 and a write in flight
    iss_valid = 1'b1; iss_rd = 3'd2;
    cycle();
    iss_valid = 1'b0;
    m_valid = 1'b1; m_rd = 3'd7; m_data = 16'h7777;
    cycle();
    m_valid = 1'b0;
    check("pre_rst_busy", busy, 8'h24);
    check("pre_rst_we", gpr_we, 1'b1);
    rst_n = 1'b0;
    chk_rs1 = 3'd2; chk_rs2 = 3'd5; iss_rd = 3'd5;
    #1;
    check("async_busy", busy, 8'h00);
    check("async_we", gpr_we, 1'b0);
    check("async_iss_ready", iss_ready, 1'b1);
    check("async_hz1", hz1, 1'b0);
    check("async_hz2", hz2, 1'b0);
    apply_reset();
    a_valid = 1'b1; a_rd = 3'd4; a_data = 16'hC0DE;
    m_valid = 1'b1; m_rd = 3'd0; m_data = 16'hD00D;
    #1;
    check("post_rst_a_wins", a_ready, 1'b1);
    check("post_rst_m_waits", m_ready, 1'b0);
    cycle();
    a_valid = 1'b0;
    cycle();
    m_valid = 1'b0;
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
